// File: rtl/parity_rx_checker.sv
// Receive side of the parity-protected serial link: deserialises start/N data/parity/stop
// frames, checks parity (odd/even) and framing, and keeps a saturating errored-frame count.
module parity_rx_checker #(
  parameter int N            = 5,
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic             par_odd,
  input  logic             clr_count,
  output logic [N-1:0]     data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_count,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t           r_state;
  logic             r_rx_meta;
  logic             r_rx_s;
  logic [TW-1:0]    r_timer;
  logic [BW-1:0]    r_bit_idx;
  logic [N-1:0]     r_shift;
  logic             r_pbit;
  logic             r_mode;
  logic [N-1:0]     r_data_out;
  logic             r_data_valid;
  logic             r_parity_err;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_err_count;

  logic             w_last_h;
  logic             w_last_c;
  logic [N-1:0]     w_shift_next;
  logic             w_perr;
  logic             w_ferr;
  logic             w_stop_sample;
  logic             w_cnt_max;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_comb begin
    w_shift_next        = r_shift >> 1;
    w_shift_next[N-1]   = r_rx_s;
  end

  assign w_last_h      = (r_timer == TW'(H - 1));
  assign w_last_c      = (r_timer == TW'(CLKS_PER_BIT - 1));
  assign w_perr        = (^{r_shift, r_pbit}) ^ r_mode;
  assign w_ferr        = ~r_rx_s;
  assign w_stop_sample = (r_state == S_STOP) && w_last_c;
  assign w_cnt_max     = (r_err_count == {CNT_W{1'b1}});

  // Output handshake: valid-only, no ready. data_valid is a one-cycle strobe and
  // data_out/parity_err/frame_err stay stable until the next frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_pbit       <= 1'b0;
      r_mode       <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_timer <= '0;
          end
        end
        S_START: begin
          if (w_last_h) begin
            r_timer <= '0;
            if (r_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_mode    <= par_odd;
              r_bit_idx <= '0;
              r_state   <= S_DATA;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DATA: begin
          if (w_last_c) begin
            r_timer <= '0;
            r_shift <= w_shift_next;
            if (r_bit_idx == BW'(N - 1)) begin
              r_state <= S_PARITY;
            end else begin
              r_bit_idx <= r_bit_idx + BW'(1);
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_PARITY: begin
          if (w_last_c) begin
            r_timer <= '0;
            r_pbit  <= r_rx_s;
            r_state <= S_STOP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_STOP: begin
          if (w_last_c) begin
            r_timer      <= '0;
            r_data_out   <= r_shift;
            r_parity_err <= w_perr;
            r_frame_err  <= w_ferr;
            r_data_valid <= 1'b1;
            r_state      <= w_ferr ? S_WAIT_IDLE : S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_WAIT_IDLE: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Clear wins over a coincident errored-frame increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (clr_count) begin
      r_err_count <= '0;
    end else if (w_stop_sample && (w_perr || w_ferr) && !w_cnt_max) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign err_count  = r_err_count;
  assign busy       = (r_state != S_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: doc/parity_rx_checker.md
Name: parity_rx_checker

Overview:
- Receive end of the team's parity-protected serial link.
- Deserialises UART-style frames: start bit, N data bits LSB first, one parity bit, one stop bit.
- Recomputes parity on the received data, compares it with the transmitted parity bit under the selected odd/even mode, and reports parity and framing errors.
- Keeps a saturating error counter for link-health monitoring.

Parameters:
- N, 5, data bits per frame (>=1).
- CLKS_PER_BIT, 4, clock cycles per serial bit (>=2).
- CNT_W, 8, error counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high; asynchronous to clk.
- par_odd  input  1  1 = odd parity expected, 0 = even parity expected.
- clr_count  input  1  synchronous clear of err_count.
- data_out  output  N  last received data word.
- data_valid  output  1  one-cycle pulse; frame complete.
- parity_err  output  1  parity mismatch on the last frame; valid while data_valid=1.
- frame_err  output  1  stop bit sampled low on the last frame; valid while data_valid=1.
- err_count  output  CNT_W  count of errored frames; saturates.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Input synchronisation:
  - rx passes through a 2-flop synchroniser; its output is rx_s.
  - All timing below is referenced to rx_s.
- Reset values (async, rst_n=0): state=IDLE, data_out=0, data_valid=0, parity_err=0, frame_err=0, err_count=0, busy=0. Synchroniser flops reset to 1.
- State machine: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. Let t = first cycle in IDLE with rx_s=0, H = CLKS_PER_BIT/2 (integer division), C = CLKS_PER_BIT.
  - IDLE: on rx_s=0 go to START and clear the bit-timer.
  - START: sample at t+H.
    - rx_s=1: false start, return to IDLE; no outputs change.
    - rx_s=0: latch par_odd for this frame, go to DATA.
  - DATA: bit i (i=0..N-1) is sampled at t+H+(i+1)*C and shifted in LSB first. After bit N-1, go to PARITY.
  - PARITY: parity bit sampled at t+H+(N+1)*C. Go to STOP.
  - STOP: stop bit sampled at t+H+(N+2)*C. Evaluated on the sample cycle:
    - perr = (^{data,pbit}) XOR latched par_odd, so that "odd total" is correct in odd mode and "even total" is correct in even mode.
    - ferr = stop sample == 0.
    - If ferr=0 go to IDLE; otherwise go to WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s=1, then go to IDLE. A held-low line (break) therefore yields exactly one errored frame.
- Output timing:
  - data_out, parity_err and frame_err are registered on the stop-sample cycle.
  - data_valid is high for exactly the following cycle (latency of 1 clock after the stop sample).
  - data_out, parity_err and frame_err hold until the next frame completes.
  - Both error flags are reported on a framing error; data_out is still updated.
- par_odd changes mid-frame have no effect on the current frame.
- err_count:
  - +1 on each completed frame with perr|ferr; +1 only, even if both are set.
  - Holds at 2^CNT_W-1.
  - clr_count=1 zeroes it and takes priority over a coincident increment.
- A new start bit can be detected on the first IDLE cycle after STOP, giving back-to-back frames with no extra idle bit.
- rst_n asserted mid-frame: immediate return to reset values. The partial frame is discarded and no data_valid is produced.

Test Plan:
- Even mode (par_odd=0), send data 5'b00011 with pbit=0, stop=1 -> data_valid pulse exactly 1 cycle after the stop sample; data_out=00011, parity_err=0, frame_err=0, err_count=0.
- Even mode, send 5'b00111 with pbit=0 (wrong) -> parity_err=1, frame_err=0, err_count=1. Repeat with pbit=1 -> parity_err=0, err_count stays 1.
- Odd mode, send 00011 with pbit=1 -> no error. Toggle par_odd mid-frame -> result unchanged.
- Send 00011 with stop=0 and hold rx low for 3 bit-times -> exactly one data_valid with frame_err=1, err_count +1. No further frame until rx returns high.
- Glitch: rx low for 1 cycle only (shorter than H) -> no data_valid, busy returns low. Also reset mid-DATA -> all outputs 0, next clean frame received correctly.
- CNT_W=2: 4 bad frames -> err_count saturates at 3. clr_count coincident with the next bad frame -> err_count=0.
